// File: rtl/pulp_hwpe_tcdm_bridge.sv
// Buffered HWPE-to-TCDM bridge: per-port request FIFO and outstanding-response counter,
// activity-derived busy, and a clear/drain sequence that never drops buffered requests.

module pulp_hwpe_tcdm_bridge_port #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            acc_req_i,
  output logic            acc_gnt_o,
  input  logic [AW-1:0]   acc_add_i,
  input  logic            acc_wen_i,
  input  logic [DW/8-1:0] acc_be_i,
  input  logic [DW-1:0]   acc_wdata_i,
  output logic            tcdm_req_o,
  output logic [AW-1:0]   tcdm_add_o,
  output logic            tcdm_wen_o,
  output logic [DW/8-1:0] tcdm_be_o,
  output logic [DW-1:0]   tcdm_wdata_o,
  input  logic            tcdm_gnt_i,
  input  logic            tcdm_r_valid_i,
  output logic            push_o,
  output logic            empty_o,
  output logic            cnt_zero_o,
  output logic            spur_o
);
  localparam int BW = DW/8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(FIFO_DEPTH+2);

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  req_t [FIFO_DEPTH-1:0] mem_q;
  req_t                  head, in_req;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  full, push, pop, rsp_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Grant looks only at registered occupancy: a pop this cycle does not free a slot yet.
  assign full      = (occ_q == OW'(FIFO_DEPTH));
  assign acc_gnt_o = en_i & ~full;
  assign push      = acc_req_i & acc_gnt_o;
  assign in_req    = '{add: acc_add_i, wen: acc_wen_i, be: acc_be_i, wdata: acc_wdata_i};

  assign tcdm_req_o   = (occ_q != '0);
  assign pop          = tcdm_req_o & tcdm_gnt_i;
  assign head         = mem_q[rptr_q];
  assign tcdm_add_o   = head.add;
  assign tcdm_wen_o   = head.wen;
  assign tcdm_be_o    = head.be;
  assign tcdm_wdata_o = head.wdata;

  assign rsp_ok = tcdm_r_valid_i & (cnt_q != '0);
  assign spur_o = tcdm_r_valid_i & (cnt_q == '0);

  always_comb begin
    occ_d = occ_q;
    if (push & ~pop)      occ_d = occ_q + OW'(1);
    else if (~push & pop) occ_d = occ_q - OW'(1);
    cnt_d = cnt_q + CW'(pop) - CW'(rsp_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_req;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign push_o     = push;
  assign empty_o    = ~tcdm_req_o;
  assign cnt_zero_o = (cnt_q == '0);
endmodule

module pulp_hwpe_tcdm_bridge #(
  parameter int N_MASTER_PORT = 4,
  parameter int DW            = 32,
  parameter int AW            = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear_i,
  input  logic                                hwpe_busy_i,
  input  logic [N_MASTER_PORT-1:0]            acc_req_i,
  output logic [N_MASTER_PORT-1:0]            acc_gnt_o,
  input  logic [N_MASTER_PORT-1:0][AW-1:0]    acc_add_i,
  input  logic [N_MASTER_PORT-1:0]            acc_wen_i,
  input  logic [N_MASTER_PORT-1:0][DW/8-1:0]  acc_be_i,
  input  logic [N_MASTER_PORT-1:0][DW-1:0]    acc_wdata_i,
  output logic [N_MASTER_PORT-1:0][DW-1:0]    acc_r_data_o,
  output logic [N_MASTER_PORT-1:0]            acc_r_valid_o,
  output logic [N_MASTER_PORT-1:0]            tcdm_req_o,
  output logic [N_MASTER_PORT-1:0][AW-1:0]    tcdm_add_o,
  output logic [N_MASTER_PORT-1:0]            tcdm_wen_o,
  output logic [N_MASTER_PORT-1:0][DW/8-1:0]  tcdm_be_o,
  output logic [N_MASTER_PORT-1:0][DW-1:0]    tcdm_wdata_o,
  input  logic [N_MASTER_PORT-1:0]            tcdm_gnt_i,
  input  logic [N_MASTER_PORT-1:0][DW-1:0]    tcdm_r_data_i,
  input  logic [N_MASTER_PORT-1:0]            tcdm_r_valid_i,
  output logic                                busy_o,
  output logic                                drained_o,
  output logic                                err_o
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e                   state_q;
  logic                     busy_q, drained_q, err_q;
  logic                     accept_en, any_push, all_empty, all_cnt_zero, all_idle;
  logic [N_MASTER_PORT-1:0] push, empty, cnt_zero, spur;

  // Gating with rst_n keeps acc_gnt_o low while reset is asserted.
  assign accept_en = rst_n & (state_q != DRAIN);

  for (genvar p = 0; p < N_MASTER_PORT; p++) begin : gen_port
    pulp_hwpe_tcdm_bridge_port #(
      .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_port (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_i           (accept_en),
      .acc_req_i      (acc_req_i[p]),
      .acc_gnt_o      (acc_gnt_o[p]),
      .acc_add_i      (acc_add_i[p]),
      .acc_wen_i      (acc_wen_i[p]),
      .acc_be_i       (acc_be_i[p]),
      .acc_wdata_i    (acc_wdata_i[p]),
      .tcdm_req_o     (tcdm_req_o[p]),
      .tcdm_add_o     (tcdm_add_o[p]),
      .tcdm_wen_o     (tcdm_wen_o[p]),
      .tcdm_be_o      (tcdm_be_o[p]),
      .tcdm_wdata_o   (tcdm_wdata_o[p]),
      .tcdm_gnt_i     (tcdm_gnt_i[p]),
      .tcdm_r_valid_i (tcdm_r_valid_i[p]),
      .push_o         (push[p]),
      .empty_o        (empty[p]),
      .cnt_zero_o     (cnt_zero[p]),
      .spur_o         (spur[p])
    );
  end

  assign acc_r_data_o  = tcdm_r_data_i;
  assign acc_r_valid_o = tcdm_r_valid_i;

  assign any_push     = |push;
  assign all_empty    = &empty;
  assign all_cnt_zero = &cnt_zero;
  assign all_idle     = all_empty & all_cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      drained_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      drained_q <= 1'b0;
      err_q     <= err_q | (|spur);
      busy_q    <= hwpe_busy_i | ~all_empty | ~all_cnt_zero | (state_q == DRAIN);
      case (state_q)
        IDLE: begin
          if (clear_i)                       state_q <= DRAIN;
          else if (any_push || hwpe_busy_i)  state_q <= ACTIVE;
        end
        ACTIVE: begin
          // A push this cycle means the FIFO is non-empty next cycle, so stay.
          if (clear_i)                                     state_q <= DRAIN;
          else if (all_idle && !hwpe_busy_i && !any_push)  state_q <= IDLE;
        end
        DRAIN: begin
          if (all_idle) begin
            state_q   <= IDLE;
            drained_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign drained_o = drained_q;
  assign err_o     = err_q;
endmodule
